serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//   Sequencer that reuses one fulladder cell (ports a,b,c,sum,carryout) to add two
//   WIDTH-bit operands bit-serially, LSB first, one bit per clock.
//   Captures operands on a start handshake and drives the shared cell from shift registers.
//   Holds the carry in a flop between bits, assembles the result and reports completion.
//   Serves as the area-minimal adder option beside the combinational fulladder/ripple blocks.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range WIDTH >= 2
// PORTS
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous, active-high reset
//   start     in   1      request; sampled only in IDLE
//   a_in      in   WIDTH  operand A, captured on accepted start
//   b_in      in   WIDTH  operand B, captured on accepted start
//   cin       in   1      carry-in, captured on accepted start
//   busy      out  1      high when state != IDLE
//   done      out  1      one-cycle pulse: sum_out/carryout hold a new result
//   sum_out   out  WIDTH  result a_in+b_in+cin mod 2^WIDTH; held until next done
//   carryout  out  1      carry out of bit WIDTH-1; held with sum_out
// BEHAVIOUR
//   - Reset: state=IDLE; busy, done, sum_out and carryout are all 0; internal shift registers,
//     carry flop and counter are 0.
//   - Reset mid-operation has the same effect: the partial result is discarded and sum_out
//     is not updated.
//   - FSM states:
//       IDLE  -> SHIFT  on start=1. Load a_sh<=a_in, b_sh<=b_in, cy<=cin, cnt<=0.
//       SHIFT -> SHIFT  while cnt < WIDTH-1.
//       SHIFT -> DONE   on the edge that processes bit WIDTH-1.
//       DONE  -> IDLE   unconditionally on the next edge.
//   - Each SHIFT edge:
//       * Drive the fulladder with a=a_sh[0], b=b_sh[0], c=cy.
//       * Shift a_sh and b_sh right by 1.
//       * Shift the fulladder sum into the MSB of an internal res_sh register (res_sh shifts right).
//       * Update cy<=carryout and cnt<=cnt+1.
//   - cnt is $clog2(WIDTH) bits wide and never wraps inside one operation.
//   - On the SHIFT->DONE edge:
//       * Load sum_out with the full assembled result, including the final bit.
//       * Load carryout with the final carryout of the cell.
//       * Register done<=1.
//     sum_out never shows partial results.
//   - done is high only in DONE, for exactly 1 cycle.
//   - Timing: if start is accepted at edge k, done is high in the cycle after edge k+WIDTH.
//     Minimum spacing between accepted starts is WIDTH+2 edges.
//   - start while busy=1 (SHIFT or DONE) is ignored, not queued.
//   - a_in/b_in/cin changes after capture have no effect.
//   - start held high continuously gives back-to-back operations: each new start is accepted
//     in IDLE, the cycle after done.
//   - Simultaneous rst and start: rst wins.
//   - busy rises on the edge after start is accepted and falls on the DONE->IDLE edge.
//   - cin=1 with a_in=b_in=all-ones gives sum_out=all-ones, carryout=1; no overflow flag is needed.
// TESTING
//   1. Assert rst for 2 cycles with start=1 -> busy=0, done=0, sum_out=0, carryout=0, no
//      operation starts.
//   2. WIDTH=8: a_in=8'h3C, b_in=8'h5A, cin=0, pulse start -> done exactly 8 edges after the
//      start edge; sum_out=8'h96, carryout=0; busy high for 9 cycles.
//   3. Carry ripple: a_in=8'hFF, b_in=8'h01, cin=0 -> sum_out=8'h00, carryout=1.
//      Then a_in=8'hFF, b_in=8'hFF, cin=1 -> sum_out=8'hFF, carryout=1.
//   4. Pulse start with 8'h10+8'h20, then change a_in/b_in and pulse start again mid-SHIFT
//      -> one done only, sum_out=8'h30; the second start is ignored.
//   5. Hold start=1 with operands 8'h01+8'h01 -> done pulses every 10 cycles, sum_out=8'h02
//      each time.
//   6. Assert rst at the 4th SHIFT cycle -> busy=0, sum_out=0 next cycle, no done pulse.
//      A following op 8'h7F+8'h01 gives 8'h80, carryout=0.
//   7. WIDTH=4: exhaustive sweep of all 512 {a_in,b_in,cin} combinations ->
//      {carryout,sum_out} == a_in+b_in+cin each time.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder sequencer. A single full-adder cell is reused once per
//   clock to add two WIDTH-bit operands LSB first. Operands and carry-in are
//   captured on an accepted start. The carry is held in a flop between bits.
//   The result is assembled in a shift register and is published to sum_out
//   and carryout only when the last bit has been processed.
//
//   Ports
//     clk       in   1      rising-edge clock
//     rst       in   1      synchronous, active-high reset
//     start     in   1      request, sampled only while idle
//     a_in      in   WIDTH  operand A, captured on accepted start
//     b_in      in   WIDTH  operand B, captured on accepted start
//     cin       in   1      carry-in, captured on accepted start
//     busy      out  1      high while an operation is in flight (SHIFT/DONE)
//     done      out  1      one-cycle pulse, new result on sum_out/carryout
//     sum_out   out  WIDTH  (a_in + b_in + cin) mod 2^WIDTH, held until next done
//     carryout  out  1      carry out of bit WIDTH-1, held with sum_out
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; outputs hold the last result
//   SHIFT | one operand bit per clock through the shared full adder
//   DONE  | result published, done pulse high for this one cycle
// ----------------------------------------------------------------------------

module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carryout
);
  assign sum      = a ^ b ^ c;
  assign carryout = (a & b) | (c & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carryout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_out_q, sum_out_d;
  logic             carryout_q, carryout_d;

  logic fa_sum;
  logic fa_cout;

  fulladder u_fa (
    .a        (a_sh_q[0]),
    .b        (b_sh_q[0]),
    .c        (cy_q),
    .sum      (fa_sum),
    .carryout (fa_cout)
  );

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    res_sh_d   = res_sh_q;
    cy_d       = cy_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    sum_out_d  = sum_out_q;
    carryout_d = carryout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          cy_d    = cin;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = {fa_sum, res_sh_q[WIDTH-1:1]};
        cy_d     = fa_cout;
        if (cnt_q == CNT_LAST) begin
          // Publish the assembled word including the bit produced this edge,
          // so sum_out never exposes a partial result.
          state_d    = ST_DONE;
          done_d     = 1'b1;
          sum_out_d  = res_sh_d;
          carryout_d = fa_cout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_sh_q   <= '0;
      cy_q       <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sum_out_q  <= '0;
      carryout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      res_sh_q   <= res_sh_d;
      cy_q       <= cy_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sum_out_q  <= sum_out_d;
      carryout_q <= carryout_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum_out  = sum_out_q;
  assign carryout = carryout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Bench for serial_adder_ctrl. An 8-bit instance covers reset, latency,
//   carry ripple, ignored starts, back-to-back operation and mid-op reset.
//   A 4-bit instance is swept over every operand/carry-in combination.
//   Expected results are pushed to a queue when an operation is launched
//   and popped when the design pulses done.
// ----------------------------------------------------------------------------

module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, carry8;
  logic [7:0] sum8;

  logic       start4;
  logic [3:0] a4, b4;
  logic       cin4;
  logic       busy4, done4, carry4;
  logic [3:0] sum4;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_done8 = 0;
  int n_done4 = 0;

  logic [8:0] exp8_q[$];
  logic [4:0] exp4_q[$];

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .start    (start8),
    .a_in     (a8),
    .b_in     (b8),
    .cin      (cin8),
    .busy     (busy8),
    .done     (done8),
    .sum_out  (sum8),
    .carryout (carry8)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .start    (start4),
    .a_in     (a4),
    .b_in     (b4),
    .cin      (cin4),
    .busy     (busy4),
    .done     (done4),
    .sum_out  (sum4),
    .carryout (carry4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest launched operation.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      n_done8++;
      if (exp8_q.size() == 0) check("done8_unexpected", 32'd1, 32'd0);
      else check("result8", {23'd0, carry8, sum8}, {23'd0, exp8_q.pop_front()});
    end
    if (done4 === 1'b1) begin
      n_done4++;
      if (exp4_q.size() == 0) check("done4_unexpected", 32'd1, 32'd0);
      else check("result4", {27'd0, carry4, sum4}, {27'd0, exp4_q.pop_front()});
    end
  end

  task automatic wait_done8(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done8 !== 1'b1 && n < 40);
  endtask

  // Launch one 8-bit op from idle; check latency, busy length and hold.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int n;
    int busy_n;
    logic [8:0] e;
    e = {1'b0, a} + {1'b0, b} + {8'd0, c};
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    exp8_q.push_back(e);
    n = 0; busy_n = 0;
    do begin
      @(negedge clk);
      start8 = 1'b0;
      n++;
      if (busy8 === 1'b1) busy_n++;
    end while (done8 !== 1'b1 && n < 30);
    check("latency8", n, 9);
    check("busy8_cycles", busy_n, 9);
    @(negedge clk);
    check("busy8_after", {31'd0, busy8}, 0);
    check("done8_width", {31'd0, done8}, 0);
    check("hold8", {23'd0, carry8, sum8}, {23'd0, e});
  endtask

  initial begin
    int n, c1, c2, c3, d0;
    rst = 1'b1;
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
    start4 = 1'b1; a4 = 4'h3;  b4 = 4'h4;  cin4 = 1'b0;

    // Reset held with start high: reset must win.
    repeat (2) @(negedge clk);
    check("rst_busy8", {31'd0, busy8}, 0);
    check("rst_done8", {31'd0, done8}, 0);
    check("rst_sum8", {24'd0, sum8}, 0);
    check("rst_carry8", {31'd0, carry8}, 0);
    check("rst_busy4", {31'd0, busy4}, 0);
    rst = 1'b0; start8 = 1'b0; start4 = 1'b0;
    @(negedge clk);
    check("post_rst_busy8", {31'd0, busy8}, 0);
    check("post_rst_busy4", {31'd0, busy4}, 0);

    // Basic add and carry ripple cases.
    run8(8'h3C, 8'h5A, 1'b0);
    run8(8'hFF, 8'h01, 1'b0);
    run8(8'hFF, 8'hFF, 1'b1);
    run8(8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    // Second start mid-SHIFT must be ignored; operand changes have no effect.
    d0 = n_done8;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    exp8_q.push_back(9'h030);
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h44; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    wait_done8(n);
    check("ignored_done_seen", {31'd0, done8}, 1);
    repeat (14) @(negedge clk);
    check("ignored_done_count", n_done8 - d0, 1);
    check("ignored_sum", {24'd0, sum8}, 32'h30);

    // Start held high: back-to-back ops, done every WIDTH+2 cycles.
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    repeat (3) exp8_q.push_back(9'h002);
    wait_done8(n); c1 = cyc;
    wait_done8(n); c2 = cyc;
    wait_done8(n); c3 = cyc;
    start8 = 1'b0;
    check("b2b_spacing1", c2 - c1, 10);
    check("b2b_spacing2", c3 - c2, 10);
    repeat (14) @(negedge clk);
    check("b2b_queue_drained", exp8_q.size(), 0);
    check("b2b_idle", {31'd0, busy8}, 0);

    // Reset in the 4th SHIFT cycle discards the op.
    d0 = n_done8;
    a8 = 8'h55; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pre_abort_busy", {31'd0, busy8}, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy8}, 0);
    check("abort_sum", {24'd0, sum8}, 0);
    check("abort_carry", {31'd0, carry8}, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_done", n_done8 - d0, 0);
    run8(8'h7F, 8'h01, 1'b0);

    // Exhaustive 4-bit sweep.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      a4 = v[8:5]; b4 = v[4:1]; cin4 = v[0];
      exp4_q.push_back({1'b0, v[8:5]} + {1'b0, v[4:1]} + {4'd0, v[0]});
      start4 = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        start4 = 1'b0;
        n++;
      end while (done4 !== 1'b1 && n < 20);
      check("latency4", n, 5);
      @(negedge clk);
    end
    check("sweep_done_count", n_done4, 512);
    check("sweep_queue_drained", exp4_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
